// File: rtl/nvdla_cvif_wr_sched_pkg.sv
// Shared types, sizes and small helpers for the CVIF write-ingress scheduler.
package cvif_wr_sched_pkg;

    localparam int NUM_REQ  = 5;
    localparam int WEIGHT_W = 8;
    localparam int LEN_W    = 2;
    localparam int ID_W     = 3;
    localparam int OS_W     = 9;

    localparam logic [ID_W-1:0] BDMA = 3'd0;
    localparam logic [ID_W-1:0] SDP  = 3'd1;
    localparam logic [ID_W-1:0] PDP  = 3'd2;
    localparam logic [ID_W-1:0] CDP  = 3'd3;
    localparam logic [ID_W-1:0] RBK  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DAT  = 2'd2
    } state_e;

    function automatic logic [OS_W-1:0] beats(input logic [LEN_W-1:0] len);
        return OS_W'(len) + OS_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Client index k positions after base, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NUM_REQ;
        return ID_W'(sum);
    endfunction

endpackage

// File: rtl/nvdla_cvif_wr_sched_if.sv
// Command/data handshake bundle between the write clients, the scheduler and the splitter.
interface nvdla_cvif_wr_sched_if;
    import cvif_wr_sched_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       dat_valid;
    logic [NUM_REQ-1:0]       dat_ready;
    logic                     gnt_vld;
    logic                     gnt_rdy;
    logic [ID_W-1:0]          gnt_id;
    logic [LEN_W-1:0]         gnt_len;
    logic [ID_W-1:0]          dat_sel;
    logic                     dat_out_vld;
    logic                     dat_out_rdy;
    logic                     dat_out_last;
    logic                     eg2ig_axi_vld;
    logic [LEN_W-1:0]         eg2ig_axi_len;

    modport master (
        input  req_valid, req_len, dat_valid, gnt_rdy, dat_out_rdy, eg2ig_axi_vld, eg2ig_axi_len,
        output req_ready, dat_ready, gnt_vld, gnt_id, gnt_len, dat_sel, dat_out_vld, dat_out_last
    );

    modport slave (
        output req_valid, req_len, dat_valid, gnt_rdy, dat_out_rdy, eg2ig_axi_vld, eg2ig_axi_len,
        input  req_ready, dat_ready, gnt_vld, gnt_id, gnt_len, dat_sel, dat_out_vld, dat_out_last
    );

endinterface

// File: rtl/nvdla_cvif_wr_sched_rr_pick.sv
// Rotating-priority picker: first asserted request strictly after last_win, wrapping around.
module cvif_wr_rr_pick
    import cvif_wr_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    last_win,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [ID_W-1:0]    win_idx,
    output logic               found
);

    // Scan from the client after last_win; the previous winner itself is checked last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[rot_idx(last_win, k)]) begin
                win_oh[rot_idx(last_win, k)] = 1'b1;
                win_idx                      = rot_idx(last_win, k);
                found                        = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/nvdla_cvif_wr_sched.sv
// Weighted round-robin issue scheduler for the five CVIF write clients, with
// burst data-path locking and an outstanding-beat budget fed by completion returns.
module nvdla_cvif_wr_sched
    import cvif_wr_sched_pkg::*;
(
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rst,
    input  logic [NUM_REQ*WEIGHT_W-1:0] reg2dp_wr_weight,
    input  logic [7:0]                  reg2dp_wr_os_cnt,
    output logic                        os_err,
    nvdla_cvif_wr_sched_if.master       bus
);

    state_e              state_r, state_nxt_s;
    logic [WEIGHT_W-1:0] credit_r [NUM_REQ];
    logic [OS_W-1:0]     os_used_r, os_nxt_s, os_inc_s;
    logic [OS_W:0]       os_sum_s, os_dec_s;
    logic                os_uflow_s, os_err_r;
    logic [ID_W-1:0]     last_win_r, gnt_id_r, dat_sel_r, pick_idx_s;
    logic [LEN_W-1:0]    gnt_len_r, beat_cnt_r, pick_len_s;
    logic [LEN_W-1:0]    len_s [NUM_REQ];
    logic [NUM_REQ-1:0]  vfit_s, elig_s, cr_oh_s, rl_oh_s, pick_oh_s;
    logic [ID_W-1:0]     cr_idx_s, rl_idx_s;
    logic                cr_found_s, rl_found_s, pick_s, reload_s;
    logic                cmd_hs_s, beat_hs_s, last_beat_s;

    // A client is eligible when valid, its burst fits the budget (N+1 beats) and it has credit.
    always_comb begin
        vfit_s = '0;
        elig_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            len_s[i]  = bus.req_len[i*LEN_W +: LEN_W];
            vfit_s[i] = bus.req_valid[i] &&
                        ((os_used_r + beats(len_s[i])) <= ({1'b0, reg2dp_wr_os_cnt} + OS_W'(1)));
            elig_s[i] = vfit_s[i] && (credit_r[i] != '0);
        end
    end

    cvif_wr_rr_pick u_pick_credit (
        .elig     (elig_s),
        .last_win (last_win_r),
        .win_oh   (cr_oh_s),
        .win_idx  (cr_idx_s),
        .found    (cr_found_s)
    );

    cvif_wr_rr_pick u_pick_reload (
        .elig     (vfit_s),
        .last_win (last_win_r),
        .win_oh   (rl_oh_s),
        .win_idx  (rl_idx_s),
        .found    (rl_found_s)
    );

    assign cmd_hs_s    = (state_r == CMD) && bus.gnt_rdy;
    assign beat_hs_s   = bus.dat_out_vld && bus.dat_out_rdy;
    assign last_beat_s = beat_hs_s && (beat_cnt_r == gnt_len_r);

    // Next state; when nobody fitting holds credit, reload and pick ignoring credit.
    always_comb begin
        state_nxt_s = state_r;
        pick_s      = 1'b0;
        reload_s    = 1'b0;
        pick_idx_s  = gnt_id_r;
        pick_oh_s   = '0;
        case (state_r)
            IDLE: begin
                if (cr_found_s) begin
                    pick_s      = 1'b1;
                    pick_idx_s  = cr_idx_s;
                    pick_oh_s   = cr_oh_s;
                    state_nxt_s = CMD;
                end else if (rl_found_s) begin
                    pick_s      = 1'b1;
                    reload_s    = 1'b1;
                    pick_idx_s  = rl_idx_s;
                    pick_oh_s   = rl_oh_s;
                    state_nxt_s = CMD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMD: begin
                if (cmd_hs_s) begin
                    state_nxt_s = DAT;
                end else begin
                    state_nxt_s = CMD;
                end
            end
            DAT: begin
                if (last_beat_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DAT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Length of the picked client, selected by its one-hot.
    always_comb begin
        pick_len_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_len_s = pick_len_s | (pick_oh_s[i] ? len_s[i] : {LEN_W{1'b0}});
        end
    end

    // Outstanding beats: add the issue, subtract the return, clamp at zero on underflow.
    always_comb begin
        os_inc_s = cmd_hs_s ? beats(gnt_len_r) : '0;
        os_sum_s = {1'b0, os_used_r} + {1'b0, os_inc_s};
        os_dec_s = bus.eg2ig_axi_vld ? {1'b0, beats(bus.eg2ig_axi_len)} : '0;
        if (os_dec_s > os_sum_s) begin
            os_nxt_s   = '0;
            os_uflow_s = 1'b1;
        end else begin
            os_nxt_s   = OS_W'(os_sum_s - os_dec_s);
            os_uflow_s = 1'b0;
        end
    end

    // FSM state, grant, lock and beat registers.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_r    <= IDLE;
            gnt_id_r   <= '0;
            gnt_len_r  <= '0;
            last_win_r <= ID_W'(NUM_REQ - 1);
            dat_sel_r  <= '0;
            beat_cnt_r <= '0;
            os_used_r  <= '0;
            os_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            os_used_r <= os_nxt_s;
            os_err_r  <= os_err_r | os_uflow_s;
            if (pick_s) begin
                gnt_id_r  <= pick_idx_s;
                gnt_len_r <= pick_len_s;
            end
            if (cmd_hs_s) begin
                last_win_r <= gnt_id_r;
                dat_sel_r  <= gnt_id_r;
                beat_cnt_r <= '0;
            end else if (beat_hs_s) begin
                beat_cnt_r <= beat_cnt_r + LEN_W'(1);
            end
        end
    end

    // Per-client credits: bulk reload from the weights, saturating decrement on grant.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                credit_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reload_s) begin
                    credit_r[i] <= reg2dp_wr_weight[i*WEIGHT_W +: WEIGHT_W];
                end else if (cmd_hs_s && (gnt_id_r == ID_W'(i)) && (credit_r[i] != '0)) begin
                    credit_r[i] <= credit_r[i] - WEIGHT_W'(1);
                end
            end
        end
    end

    assign bus.gnt_vld      = (state_r == CMD);
    assign bus.gnt_id       = gnt_id_r;
    assign bus.gnt_len      = gnt_len_r;
    assign bus.req_ready    = cmd_hs_s ? onehot(gnt_id_r) : '0;
    assign bus.dat_ready    = ((state_r == DAT) && bus.dat_out_rdy) ? onehot(gnt_id_r) : '0;
    assign bus.dat_sel      = dat_sel_r;
    assign bus.dat_out_vld  = (state_r == DAT) && bus.dat_valid[gnt_id_r];
    assign bus.dat_out_last = (state_r == DAT) && (beat_cnt_r == gnt_len_r);
    assign os_err           = os_err_r;

endmodule

// File: tb/tb_nvdla_cvif_wr_sched.sv
// Scenario bench for nvdla_cvif_wr_sched: grant order, weighting, budget, stalls and reset.
module tb_nvdla_cvif_wr_sched;
    import cvif_wr_sched_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ*WEIGHT_W-1:0] weight;
    logic [7:0]                  os_cnt;
    logic                        os_err;
    int                          chk_cnt = 0;
    int                          pass_cnt = 0;
    logic [ID_W-1:0]             exp_id_q [$];
    logic                        exp_last_q [$];
    logic [ID_W-1:0]             exp_id;
    logic                        exp_last;

    nvdla_cvif_wr_sched_if bus_if ();

    nvdla_cvif_wr_sched dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .reg2dp_wr_weight (weight),
        .reg2dp_wr_os_cnt (os_cnt),
        .os_err           (os_err),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [LEN_W-1:0] l);
        bus_if.req_len[i*LEN_W +: LEN_W] = l;
    endtask

    task automatic do_reset();
        bus_if.req_valid     = '0;
        bus_if.req_len       = '0;
        bus_if.dat_valid     = '0;
        bus_if.gnt_rdy       = 1'b1;
        bus_if.dat_out_rdy   = 1'b1;
        bus_if.eg2ig_axi_vld = 1'b0;
        bus_if.eg2ig_axi_len = '0;
        weight               = {5{8'd1}};
        os_cnt               = 8'd255;
        rst                  = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_id_q.delete();
        exp_last_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        bus_if.dat_valid = '1;
        #1;
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0) $display("FAIL rst_gnt_vld: got %0b exp 0", bus_if.gnt_vld); else pass_cnt++;
        chk_cnt++; if (bus_if.gnt_id !== 3'd0) $display("FAIL rst_gnt_id: got %0d exp 0", bus_if.gnt_id); else pass_cnt++;
        chk_cnt++; if (bus_if.gnt_len !== 2'd0) $display("FAIL rst_gnt_len: got %0d exp 0", bus_if.gnt_len); else pass_cnt++;
        chk_cnt++; if (bus_if.req_ready !== 5'd0) $display("FAIL rst_req_ready: got %b exp 0", bus_if.req_ready); else pass_cnt++;
        chk_cnt++; if (bus_if.dat_ready !== 5'd0) $display("FAIL rst_dat_ready: got %b exp 0", bus_if.dat_ready); else pass_cnt++;
        chk_cnt++; if (bus_if.dat_sel !== 3'd0) $display("FAIL rst_dat_sel: got %0d exp 0", bus_if.dat_sel); else pass_cnt++;
        chk_cnt++; if (bus_if.dat_out_vld !== 1'b0) $display("FAIL rst_dat_out_vld: got %0b exp 0", bus_if.dat_out_vld); else pass_cnt++;
        chk_cnt++; if (bus_if.dat_out_last !== 1'b0) $display("FAIL rst_dat_out_last: got %0b exp 0", bus_if.dat_out_last); else pass_cnt++;
        chk_cnt++; if (os_err !== 1'b0) $display("FAIL rst_os_err: got %0b exp 0", os_err); else pass_cnt++;
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0) $display("FAIL idle_no_req_gnt: got %0b exp 0", bus_if.gnt_vld); else pass_cnt++;
    endtask

    task automatic test_rr_order();
        do_reset();
        bus_if.dat_valid = '1;
        exp_id_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        bus_if.req_valid = '1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus_if.gnt_vld && bus_if.gnt_rdy) begin
                if (exp_id_q.size() > 0) begin
                    exp_id = exp_id_q.pop_front();
                    chk_cnt++; if (bus_if.gnt_id !== exp_id) $display("FAIL rr_gnt_id: got %0d exp %0d", bus_if.gnt_id, exp_id); else pass_cnt++;
                    chk_cnt++; if (bus_if.req_ready !== onehot(exp_id)) $display("FAIL rr_req_ready: got %b exp %b", bus_if.req_ready, onehot(exp_id)); else pass_cnt++;
                    exp_last_q.push_back(1'b1);
                end else begin
                    chk_cnt++; $display("FAIL rr_extra_grant: got id %0d exp none", bus_if.gnt_id);
                end
            end
            if (bus_if.dat_out_vld && bus_if.dat_out_rdy) begin
                exp_last = (exp_last_q.size() > 0) ? exp_last_q.pop_front() : 1'b0;
                chk_cnt++; if (bus_if.dat_out_last !== exp_last) $display("FAIL rr_last: got %0b exp %0b", bus_if.dat_out_last, exp_last); else pass_cnt++;
            end
            if (exp_id_q.size() == 0 && !bus_if.gnt_vld) bus_if.req_valid = '0;
            if (exp_id_q.size() == 0 && exp_last_q.size() == 0) break;
        end
        chk_cnt++; if (exp_id_q.size() + exp_last_q.size() != 0) $display("FAIL rr_timeout: got %0d pending exp 0", exp_id_q.size() + exp_last_q.size()); else pass_cnt++;
    endtask

    task automatic test_wrr();
        do_reset();
        bus_if.dat_valid = '1;
        weight = {8'd0, 8'd0, 8'd0, 8'd1, 8'd3};
        exp_id_q = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        bus_if.req_valid = 5'b00011;
        for (int c = 0; c < 200; c++) begin
            step();
            if (bus_if.gnt_vld && bus_if.gnt_rdy && exp_id_q.size() > 0) begin
                exp_id = exp_id_q.pop_front();
                chk_cnt++; if (bus_if.gnt_id !== exp_id) $display("FAIL wrr_gnt_id: got %0d exp %0d", bus_if.gnt_id, exp_id); else pass_cnt++;
            end
            if (exp_id_q.size() == 0 && !bus_if.gnt_vld) begin
                bus_if.req_valid = '0;
                break;
            end
        end
        chk_cnt++; if (exp_id_q.size() != 0) $display("FAIL wrr_timeout: got %0d pending exp 0", exp_id_q.size()); else pass_cnt++;
        repeat (4) step();
    endtask

    task automatic test_os_limit();
        int gcnt;
        do_reset();
        bus_if.dat_valid = '1;
        os_cnt = 8'd3;
        set_len(2, 2'd3);
        bus_if.req_valid = 5'b00100;
        gcnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus_if.gnt_vld && bus_if.gnt_rdy) gcnt++;
        end
        chk_cnt++; if (gcnt != 1) $display("FAIL os_grant_count: got %0d exp 1", gcnt); else pass_cnt++;
        chk_cnt++; if (dut.os_used_r !== 9'd4) $display("FAIL os_used_full: got %0d exp 4", dut.os_used_r); else pass_cnt++;
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0) $display("FAIL os_blocked: got %0b exp 0", bus_if.gnt_vld); else pass_cnt++;
        bus_if.eg2ig_axi_vld = 1'b1;
        bus_if.eg2ig_axi_len = 2'd3;
        step();
        bus_if.eg2ig_axi_vld = 1'b0;
        chk_cnt++; if (dut.os_used_r !== 9'd0) $display("FAIL os_after_ret: got %0d exp 0", dut.os_used_r); else pass_cnt++;
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0) $display("FAIL os_ret_gnt_early: got %0b exp 0", bus_if.gnt_vld); else pass_cnt++;
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1) $display("FAIL os_ret_gnt: got %0b exp 1", bus_if.gnt_vld); else pass_cnt++;
        chk_cnt++; if (bus_if.gnt_id !== 3'd2 || bus_if.gnt_len !== 2'd3) $display("FAIL os_ret_id_len: got %0d/%0d exp 2/3", bus_if.gnt_id, bus_if.gnt_len); else pass_cnt++;
        step();
        // Budget now 5 beats with 4 in flight: client 2 no longer fits, client 0 (1 beat) does.
        os_cnt = 8'd4;
        set_len(0, 2'd0);
        bus_if.req_valid = 5'b00101;
        for (int c = 0; c < 20 && !bus_if.gnt_vld; c++) step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1 || bus_if.gnt_id !== 3'd0) $display("FAIL os_partial_fit: got vld %0b id %0d exp vld 1 id 0", bus_if.gnt_vld, bus_if.gnt_id); else pass_cnt++;
        step();
        bus_if.req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_stall();
        do_reset();
        bus_if.dat_valid = '1;
        set_len(3, 2'd2);
        bus_if.req_valid = 5'b01000;
        for (int c = 0; c < 10 && !bus_if.gnt_vld; c++) step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1 || bus_if.gnt_id !== 3'd3 || bus_if.gnt_len !== 2'd2) $display("FAIL stall_grant: got vld %0b id %0d len %0d exp 1/3/2", bus_if.gnt_vld, bus_if.gnt_id, bus_if.gnt_len); else pass_cnt++;
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        step();
        for (int c = 0; c < 20; c++) begin
            bus_if.dat_out_rdy = !(c >= 1 && c <= 5);
            #1;
            if (bus_if.dat_out_vld && bus_if.dat_out_rdy) begin
                exp_last = exp_last_q.pop_front();
                chk_cnt++; if (bus_if.dat_out_last !== exp_last) $display("FAIL stall_last: got %0b exp %0b", bus_if.dat_out_last, exp_last); else pass_cnt++;
                chk_cnt++; if (bus_if.dat_ready !== 5'b01000 || bus_if.dat_sel !== 3'd3) $display("FAIL stall_lock: got %b sel %0d exp 01000 sel 3", bus_if.dat_ready, bus_if.dat_sel); else pass_cnt++;
            end else begin
                chk_cnt++; if (dut.beat_cnt_r !== 2'd1 || bus_if.dat_out_last !== 1'b0 || bus_if.dat_ready !== 5'd0) $display("FAIL stall_hold: got cnt %0d last %0b rdy %b exp 1/0/0", dut.beat_cnt_r, bus_if.dat_out_last, bus_if.dat_ready); else pass_cnt++;
            end
            if (exp_last_q.size() == 0) break;
            step();
        end
        chk_cnt++; if (exp_last_q.size() != 0) $display("FAIL stall_timeout: got %0d pending exp 0", exp_last_q.size()); else pass_cnt++;
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0) $display("FAIL stall_bubble: got %0b exp 0", bus_if.gnt_vld); else pass_cnt++;
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1 || bus_if.gnt_id !== 3'd3) $display("FAIL stall_regrant: got vld %0b id %0d exp 1/3", bus_if.gnt_vld, bus_if.gnt_id); else pass_cnt++;
        step();
        bus_if.req_valid = '0;
        repeat (6) step();
    endtask

    task automatic test_os_same_cycle();
        do_reset();
        bus_if.dat_valid = '1;
        set_len(0, 2'd1);
        bus_if.req_valid = 5'b00001;
        for (int c = 0; c < 10 && !bus_if.gnt_vld; c++) step();
        step();
        bus_if.req_valid = '0;
        repeat (5) step();
        chk_cnt++; if (dut.os_used_r !== 9'd2) $display("FAIL same_os_pre: got %0d exp 2", dut.os_used_r); else pass_cnt++;
        bus_if.gnt_rdy = 1'b0;
        bus_if.req_valid = 5'b00001;
        for (int c = 0; c < 10 && !bus_if.gnt_vld; c++) step();
        step();
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1 || bus_if.gnt_id !== 3'd0 || bus_if.gnt_len !== 2'd1) $display("FAIL same_gnt_hold: got vld %0b id %0d len %0d exp 1/0/1", bus_if.gnt_vld, bus_if.gnt_id, bus_if.gnt_len); else pass_cnt++;
        chk_cnt++; if (bus_if.req_ready !== 5'd0) $display("FAIL same_no_ready: got %b exp 0", bus_if.req_ready); else pass_cnt++;
        bus_if.gnt_rdy = 1'b1;
        bus_if.eg2ig_axi_vld = 1'b1;
        bus_if.eg2ig_axi_len = 2'd0;
        #1;
        chk_cnt++; if (bus_if.req_ready !== 5'b00001) $display("FAIL same_req_ready: got %b exp 00001", bus_if.req_ready); else pass_cnt++;
        step();
        bus_if.eg2ig_axi_vld = 1'b0;
        bus_if.req_valid = '0;
        chk_cnt++; if (dut.os_used_r !== 9'd3) $display("FAIL same_os_mix: got %0d exp 3", dut.os_used_r); else pass_cnt++;
        chk_cnt++; if (os_err !== 1'b0) $display("FAIL same_err_early: got %0b exp 0", os_err); else pass_cnt++;
        bus_if.eg2ig_axi_vld = 1'b1;
        bus_if.eg2ig_axi_len = 2'd3;
        step();
        bus_if.eg2ig_axi_vld = 1'b0;
        chk_cnt++; if (dut.os_used_r !== 9'd0) $display("FAIL same_uflow_os: got %0d exp 0", dut.os_used_r); else pass_cnt++;
        chk_cnt++; if (os_err !== 1'b1) $display("FAIL same_uflow_err: got %0b exp 1", os_err); else pass_cnt++;
        repeat (5) step();
        chk_cnt++; if (os_err !== 1'b1) $display("FAIL same_err_sticky: got %0b exp 1", os_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_if.dat_valid = '1;
        bus_if.dat_out_rdy = 1'b0;
        set_len(2, 2'd3);
        bus_if.req_valid = 5'b00100;
        for (int c = 0; c < 10 && !bus_if.gnt_vld; c++) step();
        step();
        bus_if.dat_out_rdy = 1'b1;
        #1;
        chk_cnt++; if (bus_if.dat_ready !== 5'b00100) $display("FAIL mid_in_dat: got %b exp 00100", bus_if.dat_ready); else pass_cnt++;
        rst = 1'b1;
        step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b0 || bus_if.dat_ready !== 5'd0) $display("FAIL mid_rst_out: got vld %0b rdy %b exp 0/0", bus_if.gnt_vld, bus_if.dat_ready); else pass_cnt++;
        chk_cnt++; if (dut.os_used_r !== 9'd0) $display("FAIL mid_rst_os: got %0d exp 0", dut.os_used_r); else pass_cnt++;
        bus_if.req_valid = 5'b00111;
        rst = 1'b0;
        for (int c = 0; c < 10 && !bus_if.gnt_vld; c++) step();
        chk_cnt++; if (bus_if.gnt_vld !== 1'b1 || bus_if.gnt_id !== 3'd0) $display("FAIL mid_first_grant: got vld %0b id %0d exp 1/0", bus_if.gnt_vld, bus_if.gnt_id); else pass_cnt++;
        step();
        bus_if.req_valid = '0;
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_wrr();
        test_os_limit();
        test_stall();
        test_os_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
